// File: rtl/priv_key_gen_if.sv
// Request/response bundle for priv_key_gen: start with e/phi in, d/valid/busy/finish out.
interface priv_key_gen_if #(parameter int WIDTH = 8);
   logic               start;
   logic [WIDTH-1:0]   e;
   logic [2*WIDTH-1:0] phi;
   logic [2*WIDTH-1:0] d;
   logic               valid;
   logic               busy;
   logic               finish;

   modport master (output start, e, phi, input d, valid, busy, finish);
   modport slave  (input start, e, phi, output d, valid, busy, finish);
endinterface

// File: rtl/priv_key_gen.sv
// d = e^-1 mod phi via iterative extended Euclid, using a bit-serial
// restoring divider and a bit-serial shift-add multiplier.
module priv_key_gen #(parameter int WIDTH = 8) (
   input  logic           clk,
   input  logic           rst,
   priv_key_gen_if.slave  bus
);
   localparam int W2 = 2*WIDTH;
   localparam int TW = W2 + 2;
   localparam int CW = $clog2(W2) + 1;

   typedef enum logic [2:0] {IDLE, INIT, DIV, MUL, UPD, FIX, DONE} state_t;
   state_t state, state_nx;

   logic [WIDTH-1:0] e_l;
   logic [W2-1:0]    phi_l, r0, r1, q, rem, d_r;
   logic [TW-1:0]    t0, t1, prod;
   logic [CW-1:0]    cnt;
   logic             bad, valid_r;

   logic          last, fits, early, fix_ok;
   logic [W2:0]   trial;
   logic [W2-1:0] trial_sub, d_fix;
   logic [TW-1:0] prod_nx;

   assign last  = (cnt == CW'(W2-1));
   assign early = (e_l == '0) || (phi_l < W2'(2));

   // Restoring division step: bring down the next dividend bit held in q's MSB.
   assign trial     = {rem, q[W2-1]};
   assign fits      = (trial >= {1'b0, r1});
   assign trial_sub = trial[W2-1:0] - r1;

   // MSB-first shift-add of q*t1; wraps mod 2^TW, which is exact here.
   assign prod_nx = {prod[TW-2:0], 1'b0} + (q[W2-1] ? t1 : '0);

   // Final t0 lies in (-phi, phi), so one conditional add of phi lands in [0, phi).
   assign fix_ok = (r0 == W2'(1)) && !bad;
   assign d_fix  = t0[TW-1] ? (t0[W2-1:0] + phi_l) : t0[W2-1:0];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (bus.start) state_nx = INIT;
         INIT: state_nx = early ? FIX : DIV;
         DIV:  if (last) state_nx = MUL;
         MUL:  if (last) state_nx = UPD;
         UPD:  state_nx = (rem == '0) ? FIX : DIV;
         FIX:  state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         e_l <= '0; phi_l <= '0; r0 <= '0; r1 <= '0; q <= '0; rem <= '0;
         t0 <= '0; t1 <= '0; prod <= '0; cnt <= '0; bad <= 1'b0;
         d_r <= '0; valid_r <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               e_l   <= bus.e;
               phi_l <= bus.phi;
            end
            INIT: begin
               r0   <= phi_l;
               r1   <= W2'(e_l);
               t0   <= '0;
               t1   <= TW'(1);
               q    <= phi_l;
               rem  <= '0;
               prod <= '0;
               cnt  <= '0;
               bad  <= early;
            end
            DIV: begin
               rem <= fits ? trial_sub : trial[W2-1:0];
               q   <= {q[W2-2:0], fits};
               cnt <= last ? '0 : cnt + 1'b1;
            end
            MUL: begin
               prod <= prod_nx;
               q    <= {q[W2-2:0], 1'b0};
               cnt  <= last ? '0 : cnt + 1'b1;
            end
            UPD: begin
               r0   <= r1;
               r1   <= rem;
               t0   <= t1;
               t1   <= t0 - prod;
               q    <= r1;
               rem  <= '0;
               prod <= '0;
               cnt  <= '0;
            end
            FIX: begin
               valid_r <= fix_ok;
               d_r     <= fix_ok ? d_fix : '0;
            end
            default: ;
         endcase
      end
   end

   assign bus.d      = d_r;
   assign bus.valid  = valid_r;
   assign bus.busy   = (state != IDLE);
   assign bus.finish = (state == DONE);
endmodule

// File: tb/tb_priv_key_gen.sv
// Directed bench for priv_key_gen: known RSA pairs, degenerate inputs,
// ignored start while busy, and reset mid-computation.
module tb_priv_key_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   priv_key_gen_if #(.WIDTH(8)) bus ();
   priv_key_gen #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Issue one request, count cycles to finish (INIT cycle = 1), check result,
   // then watch for stray finish pulses. pulse_at>0 injects a start while busy.
   task automatic run(input string tag, input logic [7:0] ev, input logic [15:0] pv,
                      input logic [15:0] xd, input logic xv, input int xlat, input int pulse_at);
      int cnt;
      int extra;
      @(negedge clk);
      bus.start = 1'b1; bus.e = ev; bus.phi = pv;
      @(negedge clk);
      bus.start = 1'b0; bus.e = 8'hAA; bus.phi = 16'h5555;
      cnt = 1;
      chk({tag, "_busy_init"}, 32'(bus.busy), 32'd1);
      while (!bus.finish && cnt < 3000) begin
         bus.start = (cnt == pulse_at);
         if (cnt == pulse_at) bus.e = 8'd3;
         @(negedge clk);
         cnt++;
      end
      bus.start = 1'b0;
      chk({tag, "_lat"}, 32'(cnt), 32'(xlat));
      chk({tag, "_d"}, 32'(bus.d), 32'(xd));
      chk({tag, "_valid"}, 32'(bus.valid), 32'(xv));
      chk({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
      chk({tag, "_fin_low"}, 32'(bus.finish), 32'd0);
      chk({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
      chk({tag, "_d_hold"}, 32'(bus.d), 32'(xd));
      extra = 0;
      repeat (150) begin
         @(negedge clk);
         if (bus.finish) extra++;
      end
      chk({tag, "_extra_fin"}, 32'(extra), 32'd0);
   endtask

   initial begin
      int fin_cnt;
      bus.start = 1'b0; bus.e = '0; bus.phi = '0;
      repeat (3) @(negedge clk);
      chk("rst_d", 32'(bus.d), 32'd0);
      chk("rst_valid", 32'(bus.valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_finish", 32'(bus.finish), 32'd0);
      rst = 1'b0;

      run("e3_phi20",    8'd3,  16'd20,   16'd7,    1'b1, 102, 0);
      run("e7_phi120",   8'd7,  16'd120,  16'd103,  1'b1, 69,  0);
      run("e17_phi3120", 8'd17, 16'd3120, 16'd2753, 1'b1, 135, 0);
      run("e4_phi20",    8'd4,  16'd20,   16'd0,    1'b0, 36,  0);
      run("e1_phi20",    8'd1,  16'd20,   16'd1,    1'b1, 36,  10);
      run("e0_phi20",    8'd0,  16'd20,   16'd0,    1'b0, 3,   0);
      run("e1_phi20b",   8'd1,  16'd20,   16'd1,    1'b1, 36,  0);
      run("e5_phi1",     8'd5,  16'd1,    16'd0,    1'b0, 3,   0);
      run("e1_phi20c",   8'd1,  16'd20,   16'd1,    1'b1, 36,  0);

      // Reset in the middle of DIV abandons the job with no finish pulse.
      @(negedge clk);
      bus.start = 1'b1; bus.e = 8'd7; bus.phi = 16'd120;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (8) @(negedge clk);
      chk("mid_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_d", 32'(bus.d), 32'd0);
      chk("mid_rst_valid", 32'(bus.valid), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_finish", 32'(bus.finish), 32'd0);
      fin_cnt = 0;
      repeat (200) begin
         @(negedge clk);
         if (bus.finish || bus.busy) fin_cnt++;
      end
      chk("mid_rst_quiet", 32'(fin_cnt), 32'd0);

      run("after_rst", 8'd7, 16'd120, 16'd103, 1'b1, 69, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
